// File: rtl/i2c_txn_sequencer_pkg.sv
// rtl/i2c_txn_sequencer_pkg.sv - shared command codes, state type and tx word helper
package i2c_txn_sequencer_pkg;

  // Command codes understood by the I2C master byte engine
  localparam logic [2:0] k_cmd_start   = 3'b000;
  localparam logic [2:0] k_cmd_wr      = 3'b001;
  localparam logic [2:0] k_cmd_rd      = 3'b010;
  localparam logic [2:0] k_cmd_stop    = 3'b011;
  localparam logic [2:0] k_cmd_restart = 3'b100;

  // Sequencer states
  typedef enum logic [2:0] {
    k_seq_idle,
    k_seq_start,
    k_seq_addr,
    k_seq_wr,
    k_seq_rd,
    k_seq_stop
  } seq_state_t;

  // 9-bit tx word: data byte followed by the ACK slot value the master drives
  function automatic logic [8:0] tx_word(input logic [7:0] data, input logic ack_bit);
    return {data, ack_bit};
  endfunction

endpackage

// File: rtl/i2c_cmd_issuer.sv
// rtl/i2c_cmd_issuer.sv - command strobe and completion handshake toward the master core
module i2c_cmd_issuer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue,
  input  logic [2:0] cmd,
  input  logic [8:0] din,
  input  logic       wait_done,
  input  logic       m_ready,
  input  logic       m_done_tick,
  output logic       strobe,
  output logic       complete,
  output logic [2:0] m_cmd,
  output logic [8:0] m_din
);

  logic       busy;
  logic       wait_done_q;
  logic [2:0] cmd_q;
  logic [8:0] din_q;

  // A command goes out only when the core is idle and nothing is outstanding.
  // Byte commands finish on done_tick; START/STOP finish when m_ready returns,
  // which the core holds low the cycle after any strobe.
  assign strobe   = issue & m_ready & ~busy;
  assign complete = busy & (wait_done_q ? m_done_tick : m_ready);
  assign m_cmd    = strobe ? cmd : cmd_q;
  assign m_din    = strobe ? din : din_q;

  // Track the outstanding command and hold its code/word until the next issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      wait_done_q <= 1'b0;
      cmd_q       <= '0;
      din_q       <= '0;
    end else if (strobe) begin
      busy        <= 1'b1;
      wait_done_q <= wait_done;
      cmd_q       <= cmd;
      din_q       <= din;
    end else if (complete) begin
      busy        <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// rtl/i2c_txn_sequencer.sv - transaction-level front end for the I2C master byte engine
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rw,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             txn_done,
  output logic             txn_nack,
  output logic [2:0]       m_cmd,
  output logic [8:0]       m_din,
  output logic             m_wr_i2c,
  input  logic             m_ready,
  input  logic             m_done_tick,
  input  logic             m_ack,
  input  logic [7:0]       m_dout
);

  seq_state_t       state, state_next;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             last_byte;

  logic             issue;
  logic [2:0]       issue_cmd;
  logic [8:0]       issue_din;
  logic             issue_wait_done;
  logic             strobe;
  logic             complete;

  assign last_byte   = (cnt == LEN_W'(1));
  assign req_ready   = (state == k_seq_idle);
  assign m_wr_i2c    = strobe;
  assign wdata_ready = (state == k_seq_wr) & strobe;
  assign txn_done    = (state == k_seq_stop) & complete;

  i2c_cmd_issuer u_issuer (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue       (issue),
    .cmd         (issue_cmd),
    .din         (issue_din),
    .wait_done   (issue_wait_done),
    .m_ready     (m_ready),
    .m_done_tick (m_done_tick),
    .strobe      (strobe),
    .complete    (complete),
    .m_cmd       (m_cmd),
    .m_din       (m_din)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= k_seq_idle;
    else          state <= state_next;
  end

  // Next state and the command requested of the issuer in each state
  always_comb begin
    state_next      = state;
    issue           = 1'b0;
    issue_cmd       = k_cmd_start;
    issue_din       = '0;
    issue_wait_done = 1'b0;
    case (state)
      k_seq_idle: begin
        if (req_valid) state_next = k_seq_start;
      end
      k_seq_start: begin
        issue     = 1'b1;
        issue_cmd = k_cmd_start;
        if (complete) state_next = k_seq_addr;
      end
      k_seq_addr: begin
        issue           = 1'b1;
        issue_cmd       = k_cmd_wr;
        issue_din       = tx_word({addr_q, rw_q}, 1'b1);
        issue_wait_done = 1'b1;
        if (complete) begin
          if (m_ack || len_q == '0) state_next = k_seq_stop;
          else if (rw_q)            state_next = k_seq_rd;
          else                      state_next = k_seq_wr;
        end
      end
      k_seq_wr: begin
        // The idle core holds the bus, so waiting on wdata is unbounded
        issue           = wdata_valid;
        issue_cmd       = k_cmd_wr;
        issue_din       = tx_word(wdata, 1'b1);
        issue_wait_done = 1'b1;
        if (complete && (m_ack || last_byte)) state_next = k_seq_stop;
      end
      k_seq_rd: begin
        // Master ACKs every byte but the last, which it NACKs
        issue           = 1'b1;
        issue_cmd       = k_cmd_rd;
        issue_din       = tx_word(8'hFF, last_byte);
        issue_wait_done = 1'b1;
        if (complete && last_byte) state_next = k_seq_stop;
      end
      k_seq_stop: begin
        issue     = 1'b1;
        issue_cmd = k_cmd_stop;
        if (complete) state_next = k_seq_idle;
      end
      default: state_next = k_seq_idle;
    endcase
  end

  // Request capture, byte counter, NACK flag and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      cnt         <= '0;
      txn_nack    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        k_seq_idle: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            rw_q     <= req_rw;
            len_q    <= req_len;
            txn_nack <= 1'b0;
          end
        end
        k_seq_addr: begin
          if (complete) begin
            if (m_ack) txn_nack <= 1'b1;
            else       cnt      <= len_q;
          end
        end
        k_seq_wr: begin
          if (complete) begin
            cnt <= cnt - LEN_W'(1);
            if (m_ack) txn_nack <= 1'b1;
          end
        end
        k_seq_rd: begin
          if (complete) begin
            cnt         <= cnt - LEN_W'(1);
            rdata       <= m_dout;
            rdata_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb/tb_i2c_txn_sequencer.sv - directed self-checking bench for i2c_txn_sequencer
module tb_i2c_txn_sequencer;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [6:0]       req_addr = '0;
  logic             req_rw = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic [7:0]       wdata = '0;
  logic             wdata_valid = 1'b0;
  logic             wdata_ready;
  logic [7:0]       rdata;
  logic             rdata_valid;
  logic             txn_done;
  logic             txn_nack;
  logic [2:0]       m_cmd;
  logic [8:0]       m_din;
  logic             m_wr_i2c;
  logic             m_ready = 1'b1;
  logic             m_done_tick = 1'b0;
  logic             m_ack = 1'b0;
  logic [7:0]       m_dout = '0;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .txn_done(txn_done), .txn_nack(txn_nack),
    .m_cmd(m_cmd), .m_din(m_din), .m_wr_i2c(m_wr_i2c),
    .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
  );

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0, hold_until = 0, left = 0;
  int n_accept = 0, n_done = 0, n_pop = 0, accept_cyc = 0;
  logic done_nack = 1'b0;
  bit   byte_op = 1'b0;
  logic pend_ack = 1'b0;
  logic [7:0] pend_dout = '0;
  logic [2:0] cmd_log[$];
  logic [8:0] din_log[$];
  int         cyc_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] wq[$];
  logic       ack_q[$];
  logic [7:0] rd_q[$];

  // Core model and monitor: inputs change on negedge, outputs sampled 2ns later
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      m_done_tick = 1'b0;
      if (left > 1) begin
        m_ready = 1'b0; left--;
      end else if (left == 1) begin
        m_ready = 1'b0;
        if (byte_op) begin m_done_tick = 1'b1; m_ack = pend_ack; m_dout = pend_dout; end
        left = 0;
      end else begin
        m_ready = (cyc >= hold_until);
      end
      wdata_valid = (wq.size() > 0);
      wdata = (wq.size() > 0) ? wq[0] : 8'h00;
      #2;
      if (!reset_n) begin left = 0; continue; end
      if (req_valid && req_ready) begin n_accept++; accept_cyc = cyc; end
      if (m_wr_i2c) begin
        cmd_log.push_back(m_cmd);
        cyc_log.push_back(cyc);
        byte_op = (m_cmd == 3'd1) || (m_cmd == 3'd2);
        if (byte_op) din_log.push_back(m_din);
        pend_ack  = (m_cmd == 3'd1 && ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
        pend_dout = (m_cmd == 3'd2 && rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        left = 2;
      end
      if (wdata_ready) begin n_pop++; if (wq.size() > 0) void'(wq.pop_front()); end
      if (rdata_valid) rd_log.push_back(rdata);
      if (txn_done) begin n_done++; done_nack = txn_nack; end
    end
  end

  task automatic clear_logs();
    cmd_log.delete(); din_log.delete(); cyc_log.delete(); rd_log.delete();
    wq.delete(); ack_q.delete(); rd_q.delete();
    n_accept = 0; n_done = 0; n_pop = 0;
  endtask

  task automatic start_txn(input logic [6:0] a, input logic rw, input logic [LEN_W-1:0] len);
    @(negedge clk);
    req_addr = a; req_rw = rw; req_len = len; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vectors++; if (m_wr_i2c !== 1'b0) begin miscompares++; $display("FAIL reset_m_wr_i2c: got %b expected 0", m_wr_i2c); end
    vectors++; if (m_cmd !== 3'd0) begin miscompares++; $display("FAIL reset_m_cmd: got %h expected 0", m_cmd); end
    vectors++; if (m_din !== 9'd0) begin miscompares++; $display("FAIL reset_m_din: got %h expected 0", m_din); end
    vectors++; if (wdata_ready !== 1'b0) begin miscompares++; $display("FAIL reset_wdata_ready: got %b expected 0", wdata_ready); end
    vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rdata_valid: got %b expected 0", rdata_valid); end
    vectors++; if (rdata !== 8'd0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    vectors++; if (txn_done !== 1'b0) begin miscompares++; $display("FAIL reset_txn_done: got %b expected 0", txn_done); end
    vectors++; if (txn_nack !== 1'b0) begin miscompares++; $display("FAIL reset_txn_nack: got %b expected 0", txn_nack); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write2();
    logic [2:0] exp_cmd [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd3};
    logic [8:0] exp_din [3] = '{9'h141, 9'h14B, 9'h079};
    bit ok;
    clear_logs();
    wq.push_back(8'hA5); wq.push_back(8'h3C);
    start_txn(7'h50, 1'b0, 8'd2);
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL write2_timeout: got no txn_done expected txn_done"); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL write2_done_count: got %0d expected 1", n_done); end
    vectors++; if (cmd_log.size() !== 5) begin miscompares++; $display("FAIL write2_cmd_count: got %0d expected 5", cmd_log.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL write2_cmd[%0d]: got %h expected %h", i, (i < cmd_log.size()) ? cmd_log[i] : 3'bx, exp_cmd[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= din_log.size() || din_log[i] !== exp_din[i]) begin
        miscompares++; $display("FAIL write2_din[%0d]: got %h expected %h", i, (i < din_log.size()) ? din_log[i] : 9'bx, exp_din[i]);
      end
    end
    vectors++; if (n_pop !== 2) begin miscompares++; $display("FAIL write2_pops: got %0d expected 2", n_pop); end
    vectors++; if (done_nack !== 1'b0) begin miscompares++; $display("FAIL write2_nack: got %b expected 0", done_nack); end
    vectors++;
    if (cyc_log.size() == 0 || cyc_log[0] - accept_cyc !== 1) begin
      miscompares++; $display("FAIL write2_start_latency: got %0d expected 1", (cyc_log.size() > 0) ? cyc_log[0] - accept_cyc : -1);
    end
  endtask

  task automatic test_read3();
    logic [2:0] exp_cmd [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [8:0] exp_din [4] = '{9'h143, 9'h1FE, 9'h1FE, 9'h1FF};
    logic [7:0] exp_rd [3] = '{8'h11, 8'h22, 8'h33};
    bit ok, seen;
    clear_logs();
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    start_txn(7'h50, 1'b1, 8'd3);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_log.size() >= 3) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL read3_reach_rd: got %0d cmds expected >=3", cmd_log.size()); end
    req_addr = 7'h22; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL read3_timeout: got no txn_done expected txn_done"); end
    vectors++; if (n_accept !== 1) begin miscompares++; $display("FAIL read3_busy_req_ignored: got %0d accepts expected 1", n_accept); end
    vectors++; if (cmd_log.size() !== 6) begin miscompares++; $display("FAIL read3_cmd_count: got %0d expected 6", cmd_log.size()); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL read3_cmd[%0d]: got %h expected %h", i, (i < cmd_log.size()) ? cmd_log[i] : 3'bx, exp_cmd[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= din_log.size() || din_log[i] !== exp_din[i]) begin
        miscompares++; $display("FAIL read3_din[%0d]: got %h expected %h", i, (i < din_log.size()) ? din_log[i] : 9'bx, exp_din[i]);
      end
    end
    vectors++; if (rd_log.size() !== 3) begin miscompares++; $display("FAIL read3_rdata_count: got %0d expected 3", rd_log.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= rd_log.size() || rd_log[i] !== exp_rd[i]) begin
        miscompares++; $display("FAIL read3_rdata[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 8'bx, exp_rd[i]);
      end
    end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL read3_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_addr_nack();
    logic [2:0] exp_cmd [3] = '{3'd0, 3'd1, 3'd3};
    bit ok;
    clear_logs();
    ack_q.push_back(1'b1);
    wq.push_back(8'hAA); wq.push_back(8'hBB);
    start_txn(7'h7F, 1'b0, 8'd2);
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL addr_nack_timeout: got no txn_done expected txn_done"); end
    vectors++; if (cmd_log.size() !== 3) begin miscompares++; $display("FAIL addr_nack_cmd_count: got %0d expected 3", cmd_log.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL addr_nack_cmd[%0d]: got %h expected %h", i, (i < cmd_log.size()) ? cmd_log[i] : 3'bx, exp_cmd[i]);
      end
    end
    vectors++; if (din_log.size() == 0 || din_log[0] !== 9'h1FD) begin miscompares++; $display("FAIL addr_nack_din: got %h expected 1fd", (din_log.size() > 0) ? din_log[0] : 9'bx); end
    vectors++; if (n_pop !== 0) begin miscompares++; $display("FAIL addr_nack_pops: got %0d expected 0", n_pop); end
    vectors++; if (done_nack !== 1'b1) begin miscompares++; $display("FAIL addr_nack_nack: got %b expected 1", done_nack); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL addr_nack_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_data_nack();
    logic [2:0] exp_cmd [4] = '{3'd0, 3'd1, 3'd1, 3'd3};
    logic [8:0] exp_din [2] = '{9'h141, 9'h003};
    bit ok;
    clear_logs();
    ack_q.push_back(1'b0); ack_q.push_back(1'b1);
    wq.push_back(8'h01); wq.push_back(8'h02); wq.push_back(8'h03);
    start_txn(7'h50, 1'b0, 8'd3);
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL data_nack_timeout: got no txn_done expected txn_done"); end
    vectors++; if (cmd_log.size() !== 4) begin miscompares++; $display("FAIL data_nack_cmd_count: got %0d expected 4", cmd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL data_nack_cmd[%0d]: got %h expected %h", i, (i < cmd_log.size()) ? cmd_log[i] : 3'bx, exp_cmd[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= din_log.size() || din_log[i] !== exp_din[i]) begin
        miscompares++; $display("FAIL data_nack_din[%0d]: got %h expected %h", i, (i < din_log.size()) ? din_log[i] : 9'bx, exp_din[i]);
      end
    end
    vectors++; if (n_pop !== 1) begin miscompares++; $display("FAIL data_nack_pops: got %0d expected 1", n_pop); end
    vectors++; if (done_nack !== 1'b1) begin miscompares++; $display("FAIL data_nack_nack: got %b expected 1", done_nack); end
  endtask

  task automatic test_probe();
    logic [2:0] exp_cmd [3] = '{3'd0, 3'd1, 3'd3};
    bit ok;
    clear_logs();
    start_txn(7'h2A, 1'b0, 8'd0);
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL probe_timeout: got no txn_done expected txn_done"); end
    vectors++; if (cmd_log.size() !== 3) begin miscompares++; $display("FAIL probe_cmd_count: got %0d expected 3", cmd_log.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL probe_cmd[%0d]: got %h expected %h", i, (i < cmd_log.size()) ? cmd_log[i] : 3'bx, exp_cmd[i]);
      end
    end
    vectors++; if (din_log.size() == 0 || din_log[0] !== 9'h0A9) begin miscompares++; $display("FAIL probe_din: got %h expected 0a9", (din_log.size() > 0) ? din_log[0] : 9'bx); end
    vectors++; if (done_nack !== 1'b0) begin miscompares++; $display("FAIL probe_nack_cleared: got %b expected 0", done_nack); end
  endtask

  task automatic test_max_len();
    bit ok;
    clear_logs();
    start_txn(7'h33, 1'b1, 8'd255);
    wait_done(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL maxlen_timeout: got no txn_done expected txn_done"); end
    vectors++; if (rd_log.size() !== 255) begin miscompares++; $display("FAIL maxlen_rdata_count: got %0d expected 255", rd_log.size()); end
    vectors++; if (din_log.size() !== 256) begin miscompares++; $display("FAIL maxlen_word_count: got %0d expected 256", din_log.size()); end
    vectors++; if (din_log.size() < 256 || din_log[254] !== 9'h1FE) begin miscompares++; $display("FAIL maxlen_second_last_ack: got %h expected 1fe", (din_log.size() > 254) ? din_log[254] : 9'bx); end
    vectors++; if (din_log.size() < 256 || din_log[255] !== 9'h1FF) begin miscompares++; $display("FAIL maxlen_last_nack: got %h expected 1ff", (din_log.size() > 255) ? din_log[255] : 9'bx); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    wq.push_back(8'hC3); wq.push_back(8'hC4);
    start_txn(7'h50, 1'b0, 8'd2);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_log.size() >= 3) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL rstmid_reach_wr: got %0d cmds expected >=3", cmd_log.size()); end
    hold_until = cyc + 5;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_req_ready: got %b expected 1", req_ready); end
    vectors++; if (m_wr_i2c !== 1'b0) begin miscompares++; $display("FAIL rstmid_m_wr_i2c: got %b expected 0", m_wr_i2c); end
    vectors++; if (m_cmd !== 3'd0) begin miscompares++; $display("FAIL rstmid_m_cmd: got %h expected 0", m_cmd); end
    vectors++; if (m_din !== 9'd0) begin miscompares++; $display("FAIL rstmid_m_din: got %h expected 0", m_din); end
    vectors++; if (wdata_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_wdata_ready: got %b expected 0", wdata_ready); end
    vectors++; if (txn_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_txn_done: got %b expected 0", txn_done); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d expected 0", n_done); end
  endtask

  task automatic test_after_reset();
    logic [2:0] exp_cmd [4] = '{3'd0, 3'd1, 3'd1, 3'd3};
    logic [8:0] exp_din [2] = '{9'h045, 9'h0B5};
    bit ok;
    clear_logs();
    wq.push_back(8'h5A);
    start_txn(7'h11, 1'b0, 8'd1);
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL after_reset_timeout: got no txn_done expected txn_done"); end
    vectors++; if (cmd_log.size() !== 4) begin miscompares++; $display("FAIL after_reset_cmd_count: got %0d expected 4", cmd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= cmd_log.size() || cmd_log[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL after_reset_cmd[%0d]: got %h expected %h", i, (i < cmd_log.size()) ? cmd_log[i] : 3'bx, exp_cmd[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= din_log.size() || din_log[i] !== exp_din[i]) begin
        miscompares++; $display("FAIL after_reset_din[%0d]: got %h expected %h", i, (i < din_log.size()) ? din_log[i] : 9'bx, exp_din[i]);
      end
    end
    vectors++; if (n_pop !== 1) begin miscompares++; $display("FAIL after_reset_pops: got %0d expected 1", n_pop); end
    vectors++; if (done_nack !== 1'b0) begin miscompares++; $display("FAIL after_reset_nack: got %b expected 0", done_nack); end
  endtask

  initial begin
    test_reset();
    test_write2();
    test_read3();
    test_addr_nack();
    test_data_nack();
    test_probe();
    test_max_len();
    test_reset_mid();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
